// File: rtl/two_bit_rca_pkg.sv
// Shared constants for the ripple-carry adder stage.
package two_bit_rca_pkg;

   localparam int RCA_DEFAULT_WIDTH = 2;

endpackage

// File: rtl/two_bit_rca_full_adder.sv
// Single full-adder cell; one link of the ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_p;

   assign w_p = a ^ b;
   assign s   = w_p ^ ci;
   assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/two_bit_rca.sv
// Ripple-carry adder with combinational sum/carry/overflow and a registered copy.
module two_bit_rca
   import two_bit_rca_pkg::*;
#(
   parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic [WIDTH-1:0] Sum_q,
   output logic             Cout_q,
   output logic             Ovf_q
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_sum_q;
   logic             r_cout_q;
   logic             r_ovf_q;

   assign w_carry[0] = Cin;

   // Carry enters bit 0 and ripples strictly upward, one cell at a time.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         full_adder u_fa (
            .a  (A[gi]),
            .b  (B[gi]),
            .ci (w_carry[gi]),
            .s  (w_sum[gi]),
            .co (w_carry[gi+1])
         );
      end
   endgenerate

   assign Sum  = w_sum;
   assign Cout = w_carry[WIDTH];
   assign Ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum_q  <= '0;
         r_cout_q <= 1'b0;
         r_ovf_q  <= 1'b0;
      end else begin
         r_sum_q  <= w_sum;
         r_cout_q <= w_carry[WIDTH];
         r_ovf_q  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
      end
   end

   assign Sum_q  = r_sum_q;
   assign Cout_q = r_cout_q;
   assign Ovf_q  = r_ovf_q;

endmodule

// File: tb/tb_two_bit_rca.sv
// Self-checking bench: vector table for the combinational path, scoreboard for the registered path.
module tb_two_bit_rca;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] A   = '0;
   logic [1:0] B   = '0;
   logic       Cin = 1'b0;
   logic [1:0] Sum;
   logic       Cout;
   logic       Ovf;
   logic [1:0] Sum_q;
   logic       Cout_q;
   logic       Ovf_q;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic       cin;
      logic [1:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t       tbl[9];
   logic [3:0] sb_q[$];

   two_bit_rca #(.WIDTH(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .Cin    (Cin),
      .Sum    (Sum),
      .Cout   (Cout),
      .Ovf    (Ovf),
      .Sum_q  (Sum_q),
      .Cout_q (Cout_q),
      .Ovf_q  (Ovf_q)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: unsigned sum for {cout,sum}, signed range test for overflow.
   function automatic logic [3:0] model(input logic [1:0] a, input logic [1:0] b, input logic cin);
      int u;
      int sa;
      int sb;
      int s;
      logic [2:0] ut;
      logic ov;
      u  = int'(a) + int'(b) + int'(cin);
      sa = a[1] ? int'(a) - 4 : int'(a);
      sb = b[1] ? int'(b) - 4 : int'(b);
      s  = sa + sb + int'(cin);
      ov = (s > 1) || (s < -2);
      ut = u[2:0];
      return {ov, ut};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic apply_comb(input logic [1:0] a, input logic [1:0] b, input logic cin);
      A   = a;
      B   = b;
      Cin = cin;
      #1;
   endtask

   // One registered cycle: drive at negedge, push expectation, compare after the edge.
   task automatic reg_cycle(input logic r, input logic [1:0] a, input logic [1:0] b, input logic cin);
      logic [3:0] exp;
      logic [3:0] got;
      @(negedge clk);
      rst = r;
      A   = a;
      B   = b;
      Cin = cin;
      sb_q.push_back(r ? 4'b0000 : model(a, b, cin));
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      got = {Ovf_q, Cout_q, Sum_q};
      check("reg_path", got, exp);
      $display("reg rst=%0b A=%0d B=%0d Cin=%0b -> {ovf,cout,sum}_q=%b exp=%b", r, a, b, cin, got, exp);
   endtask

   initial begin
      tbl[0] = '{a:2'd1, b:2'd1, cin:1'b0, sum:2'b10, cout:1'b0, ovf:1'b1};
      tbl[1] = '{a:2'd2, b:2'd2, cin:1'b0, sum:2'b00, cout:1'b1, ovf:1'b1};
      tbl[2] = '{a:2'd3, b:2'd1, cin:1'b0, sum:2'b00, cout:1'b1, ovf:1'b0};
      tbl[3] = '{a:2'd1, b:2'd2, cin:1'b0, sum:2'b11, cout:1'b0, ovf:1'b0};
      tbl[4] = '{a:2'd3, b:2'd3, cin:1'b1, sum:2'b11, cout:1'b1, ovf:1'b0};
      tbl[5] = '{a:2'd3, b:2'd0, cin:1'b0, sum:2'b11, cout:1'b0, ovf:1'b0};
      tbl[6] = '{a:2'd3, b:2'd0, cin:1'b1, sum:2'b00, cout:1'b1, ovf:1'b0};
      tbl[7] = '{a:2'd0, b:2'd0, cin:1'b0, sum:2'b00, cout:1'b0, ovf:1'b0};
      tbl[8] = '{a:2'd1, b:2'd0, cin:1'b1, sum:2'b10, cout:1'b0, ovf:1'b1};

      // Registers held in reset while the combinational path is exercised.
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", {Ovf_q, Cout_q, Sum_q}, 4'b0000);

      for (int i = 0; i < 9; i++) begin
         apply_comb(tbl[i].a, tbl[i].b, tbl[i].cin);
         check("table_vec", {Ovf, Cout, Sum}, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
         $display("comb A=%0d B=%0d Cin=%0b -> ovf=%0b cout=%0b sum=%b", A, B, Cin, Ovf, Cout, Sum);
      end

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 2; c++) begin
               apply_comb(2'(a), 2'(b), 1'(c));
               check("exhaustive", {Ovf, Cout, Sum}, model(2'(a), 2'(b), 1'(c)));
               $display("comb A=%0d B=%0d Cin=%0d -> ovf=%0b cout=%0b sum=%b", a, b, c, Ovf, Cout, Sum);
            end
         end
      end

      reg_cycle(1'b1, 2'd3, 2'd3, 1'b1);
      reg_cycle(1'b1, 2'd2, 2'd2, 1'b0);
      reg_cycle(1'b0, 2'd2, 2'd1, 1'b1);
      check("reg_2p1p1", {Cout_q, Sum_q}, 3'b100);
      reg_cycle(1'b0, 2'd1, 2'd1, 1'b0);
      reg_cycle(1'b0, 2'd3, 2'd3, 1'b1);
      reg_cycle(1'b1, 2'd3, 2'd3, 1'b1);
      reg_cycle(1'b0, 2'd2, 2'd2, 1'b0);
      for (int k = 0; k < 16; k++) begin
         reg_cycle((k == 9) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
      end
      check("scoreboard_empty", 4'(sb_q.size()), 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
